// File: rtl/mdu_pkg.sv
// Shared operation codes, cycle defaults and FSM encodings for the multiply/divide unit.
// Optional feature macro: MDU_MSUB_EN (enables md_msub / md_msubu).
package mdu_pkg;

  typedef enum logic [3:0] {
    MdNone  = 4'd0,
    MdMult  = 4'd1,
    MdMultu = 4'd2,
    MdDiv   = 4'd3,
    MdDivu  = 4'd4,
    MdMfhi  = 4'd5,
    MdMflo  = 4'd6,
    MdMthi  = 4'd7,
    MdMtlo  = 4'd8,
    MdMsub  = 4'd9,
    MdMsubu = 4'd10
  } md_op_e;

  localparam int unsigned MultCyclesDefault = 5;
  localparam int unsigned DivCyclesDefault  = 10;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Codes that occupy the unit for a busy period.
  function automatic logic is_multi(input logic [3:0] sel);
    logic r;
    r = (sel == MdMult) || (sel == MdMultu) || (sel == MdDiv) || (sel == MdDivu);
`ifdef MDU_MSUB_EN
    r = r || (sel == MdMsub) || (sel == MdMsubu);
`endif
    return r;
  endfunction

  function automatic logic is_div(input logic [3:0] sel);
    return (sel == MdDiv) || (sel == MdDivu);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: computes the 64-bit {HI,LO} result for a multi-cycle op.
// Optional feature macro: MDU_MSUB_EN (adds the multiply-subtract path).
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  md_sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result,
  output logic        div_zero
);

  logic signed [63:0] sa_ext, sb_ext;
  logic        [63:0] ua_ext, ub_ext;
  logic        [63:0] prod_s, prod_u;
  logic signed [31:0] sa, sb;
  logic        [31:0] q_s, r_s, q_u, r_u;

  assign sa_ext = {{32{a[31]}}, a};
  assign sb_ext = {{32{b[31]}}, b};
  assign ua_ext = {32'd0, a};
  assign ub_ext = {32'd0, b};
  assign prod_s = sa_ext * sb_ext;
  assign prod_u = ua_ext * ub_ext;

  // SV signed division truncates toward zero; remainder follows the dividend.
  assign sa  = a;
  assign sb  = b;
  assign q_s = sa / sb;
  assign r_s = sa % sb;
  assign q_u = a / b;
  assign r_u = a % b;

`ifndef MDU_MSUB_EN
  logic unused_acc;
  assign unused_acc = ^{hi, lo};
`endif

  always_comb begin
    result   = '0;
    div_zero = 1'b0;
    case (md_sel)
      MdMult:  result = prod_s;
      MdMultu: result = prod_u;
      MdDiv: begin
        div_zero = (b == 32'd0);
        result   = div_zero ? 64'd0 : {r_s, q_s};
      end
      MdDivu: begin
        div_zero = (b == 32'd0);
        result   = div_zero ? 64'd0 : {r_u, q_u};
      end
`ifdef MDU_MSUB_EN
      MdMsub:  result = {hi, lo} - prod_s;
      MdMsubu: result = {hi, lo} - prod_u;
`endif
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: issue FSM, cycle counter, pending result and HI/LO registers.
// Optional feature macro: MDU_MSUB_EN (msub/msubu decode as multi-cycle ops when defined).
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MultCyclesDefault,
  parameter int unsigned DIV_CYCLES  = DivCyclesDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  md_sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        start,
  output logic        busy,
  output logic [31:0] md_out
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [63:0]     pend_q, pend_d;
  logic            skip_q, skip_d;

  logic [63:0] arith_result;
  logic        div_zero;
  logic        issue;

  mdu_arith u_arith (
    .md_sel   (md_sel),
    .a        (a),
    .b        (b),
    .hi       (hi_q),
    .lo       (lo_q),
    .result   (arith_result),
    .div_zero (div_zero)
  );

  assign start = en & is_multi(md_sel);
  assign busy  = (state_q == StRun);
  assign issue = start & ~busy;

  always_comb begin
    md_out = '0;
    if (md_sel == MdMfhi) begin
      md_out = hi_q;
    end else if (md_sel == MdMflo) begin
      md_out = lo_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    skip_d  = skip_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          pend_d  = arith_result;
          skip_d  = div_zero;
          cnt_d   = is_div(md_sel) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
          state_d = StRun;
        end else if (en && (md_sel == MdMthi)) begin
          hi_d = a;
        end else if (en && (md_sel == MdMtlo)) begin
          lo_d = a;
        end
      end
      StRun: begin
        // Requests arriving while busy are dropped; the hazard unit prevents them.
        if (cnt_q <= CntW'(1)) begin
          if (!skip_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
      skip_q  <= skip_d;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: cycle-level arithmetic model compared every cycle, plus literal read-backs.
// Honours MDU_MSUB_EN the same way as the design.
module tb_mdu;
  import mdu_pkg::*;

  localparam int TbMult = 5;
  localparam int TbDiv  = 10;

  logic        clk = 1'b0;
  logic        reset, en;
  logic [3:0]  md_sel;
  logic [31:0] a, b;
  logic        start, busy;
  logic [31:0] md_out;

  always #5 clk = ~clk;

  mdu dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .md_sel (md_sel),
    .a      (a),
    .b      (b),
    .start  (start),
    .busy   (busy),
    .md_out (md_out)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  // Model state: architectural HI/LO, cycles of busy remaining, pending result.
  logic [31:0] m_hi = '0, m_lo = '0;
  int          m_left = 0;
  logic [63:0] m_pend = '0;
  bit          m_skip = 1'b0;

  function automatic bit tb_multi(input logic [3:0] s);
    bit r;
    r = (s >= 4'd1) && (s <= 4'd4);
`ifdef MDU_MSUB_EN
    r = r || (s == 4'd9) || (s == 4'd10);
`endif
    return r;
  endfunction

  function automatic bit tb_div_zero(input logic [3:0] s, input logic [31:0] y);
    return ((s == 4'd3) || (s == 4'd4)) && (y == 32'd0);
  endfunction

  function automatic logic [63:0] tb_op(input logic [3:0] s, input logic [31:0] x, y, hi, lo);
    int          sx, sy;
    logic [63:0] acc;
    sx  = x;
    sy  = y;
    acc = {hi, lo};
    case (s)
      4'd1:    return 64'(longint'(sx) * longint'(sy));
      4'd2:    return 64'(x) * 64'(y);
      4'd3:    return (y == 0) ? acc : {32'(sx % sy), 32'(sx / sy)};
      4'd4:    return (y == 0) ? acc : {x % y, x / y};
      4'd9:    return acc - 64'(longint'(sx) * longint'(sy));
      4'd10:   return acc - 64'(x) * 64'(y);
      default: return acc;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
      m_skip <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && !m_skip) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (en && tb_multi(md_sel)) begin
      m_pend <= tb_op(md_sel, a, b, m_hi, m_lo);
      m_skip <= tb_div_zero(md_sel, b);
      m_left <= ((md_sel == 4'd3) || (md_sel == 4'd4)) ? TbDiv : TbMult;
    end else if (en && md_sel == 4'd7) begin
      m_hi <= a;
    end else if (en && md_sel == 4'd8) begin
      m_lo <= a;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check("start", 32'(start), 32'(en && tb_multi(md_sel)));
      check("busy", 32'(busy), 32'(m_left > 0));
      check("md_out", md_out,
            (md_sel == 4'd5) ? m_hi : (md_sel == 4'd6) ? m_lo : 32'd0);
      if (m_left > 0 && en && reset && (tb_multi(md_sel) || md_sel == 4'd7 || md_sel == 4'd8))
      begin
        n_cmp++;
        n_bad++;
        $display("FAIL protocol: request code %0d while busy (t=%0t)", md_sel, $time);
      end
    end
  end

  task automatic cyc(input logic r, input logic e, input logic [3:0] s,
                     input logic [31:0] x, input logic [31:0] y);
    reset  = r;
    en     = e;
    md_sel = s;
    a      = x;
    b      = y;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  task automatic rd(input string name, input logic [3:0] s, input logic [31:0] exp);
    reset  = 1'b1;
    en     = 1'b1;
    md_sel = s;
    a      = '0;
    b      = '0;
    @(negedge clk);
    check(name, md_out, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_busy(input string name, input logic exp);
    reset  = 1'b1;
    en     = 1'b0;
    md_sel = '0;
    a      = '0;
    b      = '0;
    @(negedge clk);
    check(name, 32'(busy), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b0;
    en     = 1'b0;
    md_sel = '0;
    a      = '0;
    b      = '0;
    @(posedge clk);
    #1;
    checking = 1'b1;
    cyc(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);

    chk_busy("rst_busy", 1'b0);
    rd("rst_hi", MdMfhi, 32'h0);
    rd("rst_lo", MdMflo, 32'h0);

    cyc(1'b1, 1'b1, MdMultu, 32'hFFFF_FFFF, 32'd2);
    chk_busy("multu_busy_first", 1'b1);
    idle(3);
    chk_busy("multu_busy_last", 1'b1);
    rd("multu_hi", MdMfhi, 32'h0000_0001);
    rd("multu_lo", MdMflo, 32'hFFFF_FFFE);

    cyc(1'b1, 1'b1, MdMult, 32'hFFFF_FFFF, 32'd2);
    idle(5);
    rd("mult_hi", MdMfhi, 32'hFFFF_FFFF);
    rd("mult_lo", MdMflo, 32'hFFFF_FFFE);

    cyc(1'b1, 1'b1, MdMult, 32'h8000_0000, 32'h8000_0000);
    idle(5);
    rd("mult_min_hi", MdMfhi, 32'h4000_0000);
    rd("mult_min_lo", MdMflo, 32'h0000_0000);

    cyc(1'b1, 1'b1, MdDiv, 32'hFFFF_FFF9, 32'd2);
    idle(9);
    chk_busy("div_busy_last", 1'b1);
    rd("div_lo", MdMflo, 32'hFFFF_FFFD);
    rd("div_hi", MdMfhi, 32'hFFFF_FFFF);

    cyc(1'b1, 1'b1, MdMthi, 32'h11, 32'd0);
    cyc(1'b1, 1'b1, MdMtlo, 32'h22, 32'd0);
    cyc(1'b1, 1'b1, MdDivu, 32'd7, 32'd0);
    idle(10);
    rd("divz_hi", MdMfhi, 32'h11);
    rd("divz_lo", MdMflo, 32'h22);

    cyc(1'b1, 1'b1, MdMtlo, 32'hABCD_1234, 32'd0);
    rd("mtlo_fwd", MdMflo, 32'hABCD_1234);

    cyc(1'b1, 1'b1, MdMthi, 32'd0, 32'd0);
    cyc(1'b1, 1'b1, MdMtlo, 32'd10, 32'd0);
    cyc(1'b1, 1'b1, MdMsub, 32'd3, 32'd4);
    idle(5);
`ifdef MDU_MSUB_EN
    rd("msub_hi", MdMfhi, 32'hFFFF_FFFF);
    rd("msub_lo", MdMflo, 32'hFFFF_FFFE);
`else
    rd("msub_off_hi", MdMfhi, 32'h0);
    rd("msub_off_lo", MdMflo, 32'd10);
`endif

    cyc(1'b1, 1'b1, MdMult, 32'd5, 32'd6);
    idle(2);
    cyc(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    chk_busy("abort_busy", 1'b0);
    idle(6);
    rd("abort_hi", MdMfhi, 32'h0);
    rd("abort_lo", MdMflo, 32'h0);

    cyc(1'b1, 1'b1, MdMult, 32'd5, 32'd6);
    idle(5);
    cyc(1'b1, 1'b1, MdDivu, 32'd100, 32'd7);
    idle(10);
    rd("b2b_lo", MdMflo, 32'd14);
    rd("b2b_hi", MdMfhi, 32'd2);

    idle(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
